// File: rtl/led_count_scan.sv
// Multi-digit hex/BCD up/down counter with tick prescaler, load and
// wrap/saturate limits, driving a time-multiplexed common-anode display.
module led_count_scan #(
  parameter int DIGITS   = 2,
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 50_000,
  parameter int BCD      = 0
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  E,
  input  logic                  U,
  input  logic                  Sat,
  input  logic                  Ld,
  input  logic [4*DIGITS-1:0]   LdVal,
  output logic [4*DIGITS-1:0]   Cnt,
  output logic                  Ovf,
  output logic [DIGITS-1:0]     SegSel,
  output logic [6:0]            Seg
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [3:0] MAXD = (BCD != 0) ? 4'd9 : 4'd15;

  logic [TW-1:0]               tick_q, tick_d;
  logic [SW-1:0]               scan_q, scan_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic [DIGITS-1:0][3:0]      cnt_q, cnt_d;
  logic                        ovf_q, ovf_d;
  logic [DIGITS-1:0]           segsel_q, segsel_d;
  logic [6:0]                  seg_q, seg_d;

  logic                        tick, scan_wrap, wrap;
  logic [DIGITS-1:0]           lim, cin;
  logic [DIGITS-1:0][3:0]      stp, ldc, ld_v;
  logic [3:0]                  dig_sel;

  function automatic logic [6:0] seg_dec(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign ld_v      = LdVal;
  assign tick      = (tick_q == TW'(TICK_DIV - 1));
  assign scan_wrap = (scan_q == SW'(SCAN_DIV - 1));
  assign tick_d    = tick ? '0 : tick_q + TW'(1);
  assign scan_d    = scan_wrap ? '0 : scan_q + SW'(1);

  // Per-digit step and load clamp; a digit moves only when every lower
  // digit sits at its limit in the current direction.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    assign lim[g] = U ? (cnt_q[g] == MAXD) : (cnt_q[g] == 4'd0);
    assign stp[g] = !cin[g] ? cnt_q[g]
                  : U       ? (lim[g] ? 4'd0 : cnt_q[g] + 4'd1)
                            : (lim[g] ? MAXD : cnt_q[g] - 4'd1);
    assign ldc[g] = ((BCD != 0) && (ld_v[g] > 4'd9)) ? 4'd9 : ld_v[g];
  end

  always_comb begin
    logic acc;
    acc = 1'b1;
    cin = '0;
    for (int i = 0; i < DIGITS; i++) begin
      cin[i] = acc;
      acc    = acc & lim[i];
    end
    wrap = acc;
  end

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    if (Ld) begin
      cnt_d = ldc;
    end else if (tick && E) begin
      ovf_d = wrap;
      if (!(wrap && Sat)) cnt_d = stp;
    end
  end

  always_comb begin
    idx_d = idx_q;
    if (scan_wrap) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
  end

  // Segment data follows the index it is shown with, from the current count.
  always_comb begin
    dig_sel = cnt_q[0];
    for (int i = 1; i < DIGITS; i++)
      if (idx_d == IW'(i)) dig_sel = cnt_q[i];
    seg_d    = seg_dec(dig_sel);
    segsel_d = ~(DIGITS'(1) << idx_d);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      tick_q   <= '0;
      scan_q   <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      segsel_q <= ~DIGITS'(1);
      seg_q    <= 7'b1000000;
    end else begin
      tick_q   <= tick_d;
      scan_q   <= scan_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      segsel_q <= segsel_d;
      seg_q    <= seg_d;
    end
  end

  assign Cnt    = cnt_q;
  assign Ovf    = ovf_q;
  assign SegSel = segsel_q;
  assign Seg    = seg_q;

endmodule
